// File: rtl/cam_writer_pkg.sv
// Shared types and helpers for the camera pixel RAM writer.
package cam_writer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARMED,
        ST_CAPTURE,
        ST_FLUSH,
        ST_DONE
    } state_e;

    // One FIFO entry: {byteenable[3:0], writedata[31:0]}
    localparam int ENTRY_W = 36;

    // Number of filled lanes after a pixel (0 means all four) to byte lanes.
    function automatic logic [3:0] lanes_to_be(input logic [1:0] lanes);
        case (lanes)
            2'd1:    return 4'h1;
            2'd2:    return 4'h3;
            2'd3:    return 4'h7;
            default: return 4'hF;
        endcase
    endfunction

endpackage

// File: rtl/cam_word_fifo.sv
// Show-ahead word FIFO between the pixel packer and the Avalon write master.
module cam_word_fifo
    import cam_writer_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               push_i,
    input  logic [ENTRY_W-1:0] data_i,
    input  logic               pop_i,
    output logic [ENTRY_W-1:0] data_o,
    output logic               full_o,
    output logic               empty_o
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);

    logic [ENTRY_W-1:0] mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
    logic [PTR_W:0]     count_q;
    logic               do_push, do_pop;

    assign full_o  = (count_q == (PTR_W + 1)'(FIFO_DEPTH));
    assign empty_o = (count_q == '0);
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;
    assign data_o  = mem_q[rd_ptr_q];

    // Pointers wrap naturally because the depth is a power of two.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/cam_pixel_mem_writer.sv
// Packs one camera frame into 32-bit words and streams them into RAM over Avalon-MM.
module cam_pixel_mem_writer
    import cam_writer_pkg::*;
#(
    parameter int ADDR_W      = 10,
    parameter int DEPTH_WORDS = 1024,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              pix_sof,
    input  logic              pix_eof,
    input  logic              pix_valid,
    input  logic [7:0]        pix_data,
    output logic [ADDR_W-1:0] avm_address,
    output logic [3:0]        avm_byteenable,
    output logic              avm_chipselect,
    output logic              avm_write,
    output logic [31:0]       avm_writedata,
    input  logic              avm_waitrequest,
    output logic              busy,
    output logic              done,
    output logic              overflow,
    output logic              truncated,
    output logic [ADDR_W:0]   word_count
);

    state_e             state_q, state_d;
    logic [1:0]         lane_q, lane_d;
    logic [23:0]        pack_q, pack_d;
    logic [ADDR_W:0]    pushed_q, pushed_d;
    logic [ADDR_W:0]    wc_q, wc_d;
    logic               ovf_q, ovf_d;
    logic               trunc_q, trunc_d;

    logic               push, capture_pixel, xfer, at_cap;
    logic               fifo_full, fifo_empty;
    logic [ENTRY_W-1:0] head;
    logic [1:0]         lane_idx, lane_next;
    logic [31:0]        merged, push_word, lane_mask;
    logic [3:0]         push_be;

    assign xfer   = ~fifo_empty & ~avm_waitrequest;
    assign at_cap = (pushed_q == (ADDR_W + 1)'(DEPTH_WORDS));

    // Merge the incoming pixel into the partially built word; unfilled lanes are masked to zero.
    always_comb begin
        lane_idx  = (state_q == ST_CAPTURE) ? lane_q : 2'd0;
        lane_next = lane_idx + 2'd1;
        merged    = {8'h00, pack_q};
        merged[{lane_idx, 3'b000} +: 8] = pix_data;
        push_be   = lanes_to_be(lane_next);
        lane_mask = {{8{push_be[3]}}, {8{push_be[2]}}, {8{push_be[1]}}, {8{push_be[0]}}};
        push_word = merged & lane_mask;
    end

    always_comb begin
        state_d       = state_q;
        lane_d        = lane_q;
        pack_d        = pack_q;
        pushed_d      = pushed_q;
        ovf_d         = ovf_q;
        trunc_d       = trunc_q;
        wc_d          = xfer ? wc_q + 1'b1 : wc_q;
        push          = 1'b0;
        capture_pixel = 1'b0;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d  = ST_ARMED;
                    wc_d     = '0;
                    pushed_d = '0;
                    ovf_d    = 1'b0;
                    trunc_d  = 1'b0;
                    lane_d   = 2'd0;
                end
            end
            ST_ARMED: begin
                if (pix_valid && pix_sof) begin
                    state_d       = ST_CAPTURE;
                    capture_pixel = 1'b1;
                end
            end
            ST_CAPTURE: begin
                if (pix_valid) begin
                    if (at_cap) begin
                        trunc_d = 1'b1;
                        state_d = ST_FLUSH;
                        lane_d  = 2'd0;
                    end else begin
                        capture_pixel = 1'b1;
                    end
                end
            end
            ST_FLUSH: begin
                if (fifo_empty) state_d = ST_DONE;
            end
            default: state_d = ST_IDLE;
        endcase

        // Dropped words still count toward capacity, so the address can never wrap.
        if (capture_pixel) begin
            pack_d = merged[23:0];
            lane_d = lane_next;
            if (lane_next == 2'd0 || pix_eof) begin
                push     = 1'b1;
                pushed_d = pushed_q + 1'b1;
                if (fifo_full) ovf_d = 1'b1;
            end
            if (pix_eof) begin
                state_d = ST_FLUSH;
                lane_d  = 2'd0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            lane_q   <= 2'd0;
            pack_q   <= '0;
            pushed_q <= '0;
            wc_q     <= '0;
            ovf_q    <= 1'b0;
            trunc_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            lane_q   <= lane_d;
            pack_q   <= pack_d;
            pushed_q <= pushed_d;
            wc_q     <= wc_d;
            ovf_q    <= ovf_d;
            trunc_q  <= trunc_d;
        end
    end

    cam_word_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (push),
        .data_i  ({push_be, push_word}),
        .pop_i   (xfer),
        .data_o  (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign avm_write      = ~fifo_empty;
    assign avm_chipselect = avm_write;
    assign avm_address    = wc_q[ADDR_W-1:0];
    assign avm_byteenable = avm_write ? head[35:32] : 4'h0;
    assign avm_writedata  = avm_write ? head[31:0] : 32'h0;

    assign busy       = (state_q == ST_ARMED) || (state_q == ST_CAPTURE) || (state_q == ST_FLUSH);
    assign done       = (state_q == ST_DONE);
    assign overflow   = ovf_q;
    assign truncated  = trunc_q;
    assign word_count = wc_q;

endmodule

// File: doc/cam_pixel_mem_writer.md
Name: cam_pixel_mem_writer

Overview:
- Upstream feeder for the 1024x32 single-port on-chip RAM slave.
- Captures one frame of 8-bit camera pixels and packs 4 pixels per 32-bit word, little-endian.
- Writes the words sequentially into the RAM through an Avalon-MM write master. Nios software reads the frame back through the RAM's other slave.
- Pixel source cannot stall. The block buffers across interconnect waitrequest and flags any loss.

Parameters:
- ADDR_W, 10, word address width; matches the RAM address port.
- DEPTH_WORDS, 1024, capacity limit in words; capture stops when reached.
- FIFO_DEPTH, 4, word FIFO entries (power of 2, min 2).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous active-high reset
- start  in  1  single-cycle pulse; arms a capture
- pix_sof  in  1  frame start, qualified by pix_valid; the pixel on that cycle is pixel 0
- pix_eof  in  1  last pixel of frame, qualified by pix_valid
- pix_valid  in  1  pixel strobe
- pix_data  in  8  pixel value
- avm_address  out  ADDR_W  word address
- avm_byteenable  out  4  byte lanes
- avm_chipselect  out  1  equals avm_write
- avm_write  out  1  write request
- avm_writedata  out  32  packed pixels
- avm_waitrequest  in  1  interconnect stall
- busy  out  1  high in ARMED/CAPTURE/FLUSH
- done  out  1  sticky; capture finished
- overflow  out  1  sticky; pixel dropped (FIFO full)
- truncated  out  1  sticky; DEPTH_WORDS reached before eof
- word_count  out  ADDR_W+1  words accepted by slave this capture

Behaviour:
- Reset (sync, active-high):
  - state=IDLE.
  - All outputs 0, including avm_address=0, avm_byteenable=0, flags and word_count.
  - Pack register and lane counter cleared; FIFO emptied.
  - RAM contents untouched. Reset mid-write drops the in-flight word.
- IDLE / DONE:
  - start -> ARMED. Clears done, overflow, truncated, word_count; address=0.
  - start in any other state is ignored.
- ARMED:
  - Pixels ignored until pix_valid&pix_sof -> CAPTURE.
  - That pixel goes to lane 0.
  - If it also has pix_eof, take the flush path immediately.
- CAPTURE:
  - Each pix_valid writes pix_data into lane L, then L=L+1 mod 4.
  - On L==3, push {lane3..lane0} with byteenable=4'hF into the FIFO.
  - pix_sof in CAPTURE is ignored (treated as a normal pixel).
- FIFO full on a push:
  - Word dropped, overflow=1, capture continues.
  - Words pushed = words accepted + dropped words.
- End of frame (pix_valid&pix_eof):
  - If L!=0 after the pixel, push a partial word. Unused lanes are 0; byteenable has ones for the filled lanes only (L=1 -> 4'h1, 2 -> 4'h3, 3 -> 4'h7).
  - Then -> FLUSH.
- FLUSH:
  - Pixels ignored.
  - When the FIFO is empty and no write is pending -> DONE, done=1.
- Master side:
  - FIFO is show-ahead. avm_write=1 whenever the FIFO is non-empty, with data, byteenable and address from the head.
  - Transfer completes on a cycle with avm_write&~avm_waitrequest. Then pop, address+1, word_count+1.
  - Outputs hold stable while waitrequest=1.
  - Latency: word completed at cycle N -> avm_write high at N+1. With no waitrequest, writes are back-to-back.
- Capacity:
  - Pushes stop once pushed-word count == DEPTH_WORDS.
  - A further pixel in CAPTURE sets truncated=1 and goes to FLUSH, ignoring the rest of the frame.
  - The address therefore never wraps.
- Simultaneous push and pop in one cycle is legal; occupancy is unchanged.
- avm_byteenable=0 when avm_write=0.

Decomposition:
- Package cam_writer_pkg:
  - state enum IDLE/ARMED/CAPTURE/FLUSH/DONE
  - lane-count-to-byteenable function
  - FIFO entry width constant 36 (32 data + 4 byteenable)
- Sub-module cam_word_fifo: synchronous FIFO_DEPTH x 36, show-ahead, with full/empty, push/pop, sync reset.

Test Plan:
- start, sof, then 8 pixels 0x01..0x08 with eof on the 8th, waitrequest=0 -> writes addr0=0x04030201, addr1=0x08070605, byteenable F; done=1, word_count=2.
- 6-pixel frame 0xA0..0xA5 -> addr1 data=0x0000A5A4, byteenable=4'h3; word_count=2.
- waitrequest held 1 for 20 cycles during a 32-pixel burst with FIFO_DEPTH=4 -> overflow=1; word_count=4+words pushed after the stall releases; outputs stable while stalled.
- DEPTH_WORDS=4, 24-pixel frame -> 4 writes to addr 0..3, truncated=1, done=1, no address 4.
- Pixels before sof and a second sof mid-frame -> pre-sof pixels discarded; mid-frame sof stored as a normal pixel.
- Reset asserted during FLUSH with waitrequest=1 -> next cycle all outputs 0, state IDLE; new start/frame writes from addr 0.
